// File: rtl/digitalclock_pkg.sv
// Shared owner encoding, default durations and the alarm tone pattern
// for the clock's buzzer path.
package digitalclock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_KEY   = 2'd1,
    ST_CHIME = 2'd2,
    ST_ALARM = 2'd3
  } owner_e;

  localparam int unsigned KEY_MS_DEF          = 20;
  localparam int unsigned CHIME_SHORT_MS_DEF  = 100;
  localparam int unsigned CHIME_LONG_MS_DEF   = 500;
  localparam int unsigned ALARM_TIMEOUT_S_DEF = 60;
  localparam int unsigned ALARM_PERIOD        = 1000;
  localparam int unsigned PHASE_W             = 10;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Four 100-cycle bursts per period; windows start on even phases so the
  // tone is high on even phases inside a window.
  function automatic logic tone_slot(input logic [PHASE_W-1:0] phase);
    logic in_win;
    in_win = (phase < PHASE_W'(100)) ||
             ((phase >= PHASE_W'(200)) && (phase < PHASE_W'(300))) ||
             ((phase >= PHASE_W'(400)) && (phase < PHASE_W'(500))) ||
             ((phase >= PHASE_W'(600)) && (phase < PHASE_W'(700)));
    return in_win && !phase[0];
  endfunction

endpackage

// File: rtl/beep_timer.sv
// Loadable down-counter timing key beeps and chimes; done flags the last cycle.
module beep_timer
  import digitalclock_pkg::*;
#(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_N,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic [W-1:0] o_count,
  output logic         o_done_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_done_c = (r_count == W'(1));

endmodule

// File: rtl/buzzer_arbiter.sv
// Arbitrates the single buzzer between alarm, hourly chime and key beeps
// with fixed priority ALARM > CHIME > KEY.
module buzzer_arbiter
  import digitalclock_pkg::*;
#(
  parameter int unsigned KEY_MS          = KEY_MS_DEF,
  parameter int unsigned CHIME_SHORT_MS  = CHIME_SHORT_MS_DEF,
  parameter int unsigned CHIME_LONG_MS   = CHIME_LONG_MS_DEF,
  parameter int unsigned ALARM_TIMEOUT_S = ALARM_TIMEOUT_S_DEF
) (
  input  logic       clk,
  input  logic       rst_N,
  input  logic       alarm_en,
  input  logic       alarm_match,
  input  logic       chime_tick,
  input  logic       chime_long,
  input  logic       key_press,
  output logic       buzzer,
  output logic       ringing,
  output logic [1:0] owner
);

  localparam int unsigned DUR_MAX = max3(KEY_MS, CHIME_SHORT_MS, CHIME_LONG_MS);
  localparam int unsigned DW      = (DUR_MAX < 1) ? 1 : $clog2(DUR_MAX + 1);
  localparam int unsigned PW      = (ALARM_TIMEOUT_S < 1) ? 1 : $clog2(ALARM_TIMEOUT_S + 1);
  localparam logic [PW-1:0] PERIOD_LIMIT = PW'(ALARM_TIMEOUT_S);
  localparam logic [PW-1:0] LAST_PERIOD  = PW'((ALARM_TIMEOUT_S > 0) ? ALARM_TIMEOUT_S - 1 : 0);

  owner_e              r_state;
  logic                r_armed;
  logic                r_buzzer;
  logic                r_ringing;
  logic [PHASE_W-1:0]  r_phase;
  logic [PW-1:0]       r_periods;

  logic                w_alarm_start;
  logic                w_chime_req;
  logic                w_chime_load;
  logic                w_key_load;
  logic                w_load;
  logic [DW-1:0]       w_value;
  logic [DW-1:0]       w_timer_count;
  logic                w_timer_done;
  logic                w_expire;
  logic                w_period_end;
  logic                w_timeout;
  logic [PHASE_W-1:0]  w_phase_nxt;
  logic [PW-1:0]       w_periods_nxt;

  // Request decode; lower-priority loads are masked by any higher request.
  always_comb begin
    w_alarm_start = 1'b0;
    w_chime_req   = 1'b0;
    w_chime_load  = 1'b0;
    w_key_load    = 1'b0;
    w_value       = DW'(KEY_MS);

    w_alarm_start = alarm_en && alarm_match && r_armed && (r_state != ST_ALARM);
    w_chime_req   = chime_tick || chime_long;
    w_chime_load  = w_chime_req && (r_state != ST_ALARM) && !w_alarm_start;
    w_key_load    = key_press && ((r_state == ST_IDLE) || (r_state == ST_KEY)) &&
                    !w_alarm_start && !w_chime_req;
    if (chime_long) begin
      w_value = DW'(CHIME_LONG_MS);
    end else if (chime_tick) begin
      w_value = DW'(CHIME_SHORT_MS);
    end
  end

  assign w_load   = w_chime_load || w_key_load;
  // A zero-length load leaves the count at 0, which must also end the beep.
  assign w_expire = w_timer_done || (w_timer_count == '0);

  beep_timer #(
    .W (DW)
  ) u_beep_timer (
    .clk      (clk),
    .rst_N    (rst_N),
    .i_load   (w_load),
    .i_value  (w_value),
    .o_count  (w_timer_count),
    .o_done_c (w_timer_done)
  );

  // Alarm pattern phase and saturating completed-period count.
  always_comb begin
    w_period_end  = (r_phase == PHASE_W'(ALARM_PERIOD - 1));
    w_phase_nxt   = w_period_end ? '0 : r_phase + PHASE_W'(1);
    w_periods_nxt = r_periods;
    if (w_period_end && (r_periods != PERIOD_LIMIT)) begin
      w_periods_nxt = r_periods + PW'(1);
    end
    w_timeout     = w_period_end && (r_periods >= LAST_PERIOD);
  end

  always_ff @(posedge clk or negedge rst_N) begin
    if (!rst_N) begin
      r_state   <= ST_IDLE;
      r_armed   <= 1'b1;
      r_buzzer  <= 1'b0;
      r_ringing <= 1'b0;
      r_phase   <= '0;
      r_periods <= '0;
    end else begin
      r_phase   <= '0;
      r_periods <= '0;
      if (!alarm_match) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        ST_ALARM: begin
          if (!alarm_en) begin
            r_state   <= ST_IDLE;
            r_buzzer  <= 1'b0;
            r_ringing <= 1'b0;
          end else if (key_press || w_timeout) begin
            r_state   <= ST_IDLE;
            r_buzzer  <= 1'b0;
            r_ringing <= 1'b0;
            r_armed   <= 1'b0;
          end else begin
            r_phase   <= w_phase_nxt;
            r_periods <= w_periods_nxt;
            r_buzzer  <= tone_slot(w_phase_nxt);
          end
        end
        default: begin
          if (w_alarm_start) begin
            r_state   <= ST_ALARM;
            r_ringing <= 1'b1;
            r_buzzer  <= 1'b1;
          end else if (w_chime_load) begin
            r_state  <= ST_CHIME;
            r_buzzer <= 1'b1;
          end else if (w_key_load) begin
            r_state  <= ST_KEY;
            r_buzzer <= 1'b1;
          end else if ((r_state != ST_IDLE) && !w_expire) begin
            r_buzzer <= ~r_buzzer;
          end else begin
            r_state  <= ST_IDLE;
            r_buzzer <= 1'b0;
          end
        end
      endcase
    end
  end

  assign buzzer  = r_buzzer;
  assign ringing = r_ringing;
  assign owner   = r_state;

endmodule
